divu_seq: RTL and testbench
===========================

# divu_seq

Multi-cycle 32-bit divider controller that runs one shift-subtract iteration per clock through a single `divu_1iter` instance. It takes 32 cycles per operation. It sits between the execute-stage issue logic, which feeds it operands over a valid/ready handshake, and the writeback path, which consumes quotient and remainder over a second valid/ready handshake. The controller owns the operand, quotient and remainder registers, the iteration counter, the FSM and the divide-by-zero handling.

## Interface
- Parameters: none. Width and iteration count come from `divu_pkg`.
- Clock and reset:
  - `i_clk` input 1: single clock, all state on the rising edge.
  - `i_rst_n` input 1: asynchronous active-low reset; one clock, asynchronous active-low reset.
- Input handshake:
  - `i_valid` input 1: operands present.
  - `o_ready` output 1: block can accept operands.
  - `i_dividend` input 32: dividend.
  - `i_divisor` input 32: divisor.
  - `i_signed` input 1: signed operation. Present only with `DIVU_SIGNED_EN`.
- Output handshake:
  - `o_valid` output 1: result available.
  - `i_ready` input 1: consumer takes the result.
  - `o_quotient` output 32: quotient.
  - `o_remainder` output 32: remainder.
  - `o_div_by_zero` output 1: divisor was 0 for this result.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - `o_ready`=1.
  - On `i_valid`: latch dividend and divisor, clear the quotient and remainder registers, clear the counter, go to BUSY.
- BUSY:
  - Each edge registers the `divu_1iter` outputs (dividend, quotient, remainder) and increments the counter.
  - At the edge where counter==31, the last iteration is registered and the FSM goes to DONE.
  - `i_valid` is ignored; `o_ready`=0.
- DONE:
  - `o_valid`=1; results held stable.
  - On `i_ready`, go to IDLE.
- Unsigned arithmetic: straight restoring division.
- Divide by zero needs no special path:
  - The iteration naturally yields quotient 0xFFFFFFFF and remainder = dividend.
  - The divide-by-zero flag is latched at accept.
- Results persist on `o_quotient`/`o_remainder` in IDLE until the next accept; they are valid only while `o_valid`=1.
- Reset values:
  - `o_valid`=0, `o_quotient`=0, `o_remainder`=0, `o_div_by_zero`=0.
  - `o_ready`=1 (state IDLE).
  - Internal registers and counter 0.
- Reset mid-operation (BUSY or DONE): immediate return to IDLE; the result is discarded and no `o_valid` pulse occurs.

## Timing
- Accept on edge E0 (IDLE, `i_valid`=1).
- Iterations on E1..E32; DONE is entered at E32.
- `o_valid` is high from E32 until the edge where `i_ready`=1.
- Minimum handshake-to-handshake period: 34 cycles. One accept cycle, 32 iteration cycles, one DONE cycle with `i_ready` already high.
- `o_ready` is a decode of state only and does not depend combinationally on `i_valid`.
- `o_valid` and the results are registered or derived from registers only; there is no combinational path from any input.
- `i_ready` may be held low indefinitely; the outputs must not change meanwhile.

## Configuration
- `DIVU_SIGNED_EN` defined:
  - Adds `i_signed`.
  - At accept, when `i_signed`=1, operands are converted to magnitudes and their signs are latched.
  - In DONE:
    - The quotient is negated when the signs differ and the divisor is nonzero.
    - The remainder takes the sign of the dividend.
    - Fix-up is combinational from held registers.
  - Divide by zero gives quotient 0xFFFFFFFF and remainder = original dividend.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- `DIVU_SIGNED_EN` undefined: no `i_signed` port; unsigned only; no sign logic synthesized.

## Structure
- `divu_pkg` holds:
  - `DIVU_WIDTH`=32 and `DIVU_ITERS`=32.
  - The counter width (5).
  - The FSM state enum typedef `divu_state_t`.
- One sub-module: `divu_1iter`, instantiated once and fed from the internal registers.
- Sign pre- and post-processing is inline, inside the `DIVU_SIGNED_EN` guard.

## Test plan
- Unsigned 100/7:
  - `o_valid` rises exactly 32 cycles after accept.
  - q=14, r=2, `o_div_by_zero`=0.
- Unsigned 0xFFFFFFFF/1: q=0xFFFFFFFF, r=0.
- Divide by zero 0x1234/0: q=0xFFFFFFFF, r=0x1234, `o_div_by_zero`=1.
- Backpressure:
  - Hold `i_ready`=0 for 5 cycles after `o_valid`: outputs stay stable.
  - Pulse `i_valid` during BUSY: ignored, `o_ready`=0.
  - Releasing `i_ready` returns to IDLE.
- Reset asserted in the 10th BUSY cycle:
  - `o_valid`=0, `o_ready`=1 immediately.
  - The next op 9/3 gives q=3, r=0.
- With `DIVU_SIGNED_EN`:
  - -7/2 gives q=0xFFFFFFFD, r=0xFFFFFFFF.
  - 0x80000000/0xFFFFFFFF gives q=0x80000000, r=0.
  - -5/0 gives q=0xFFFFFFFF, r=0xFFFFFFFB.

Source files
------------

// File: rtl/divu_pkg.sv
// Shared widths, iteration count and FSM encoding for the sequential divider.
// Optional signed support is enabled by defining DIVU_SIGNED_EN.
package divu_pkg;

    localparam int DIVU_WIDTH = 32;
    localparam int DIVU_ITERS = 32;
    localparam int DIVU_CNT_W = 5;

    // Counter value at which the final iteration is registered.
    localparam logic [DIVU_CNT_W-1:0] DIVU_LAST = DIVU_CNT_W'(DIVU_ITERS - 1);

    typedef enum logic [1:0] {
        DIVU_IDLE = 2'd0,
        DIVU_BUSY = 2'd1,
        DIVU_DONE = 2'd2
    } divu_state_t;

endpackage

// File: rtl/divu_if.sv
// Operand and result handshakes of the divider; slave is the divider side.
// i_signed exists only when DIVU_SIGNED_EN is defined.
interface divu_if;
    import divu_pkg::*;

    logic                  i_valid;
    logic                  o_ready;
    logic [DIVU_WIDTH-1:0] i_dividend;
    logic [DIVU_WIDTH-1:0] i_divisor;
`ifdef DIVU_SIGNED_EN
    logic                  i_signed;
`endif
    logic                  o_valid;
    logic                  i_ready;
    logic [DIVU_WIDTH-1:0] o_quotient;
    logic [DIVU_WIDTH-1:0] o_remainder;
    logic                  o_div_by_zero;

    modport slave (
`ifdef DIVU_SIGNED_EN
        input  i_signed,
`endif
        input  i_valid,
        input  i_dividend,
        input  i_divisor,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_quotient,
        output o_remainder,
        output o_div_by_zero
    );

    modport master (
`ifdef DIVU_SIGNED_EN
        output i_signed,
`endif
        output i_valid,
        output i_dividend,
        output i_divisor,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_quotient,
        input  o_remainder,
        input  o_div_by_zero
    );

endinterface

// File: rtl/divu_1iter.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits.
module divu_1iter
    import divu_pkg::*;
(
    input  logic [DIVU_WIDTH-1:0] dividend_i,
    input  logic [DIVU_WIDTH-1:0] divisor_i,
    input  logic [DIVU_WIDTH-1:0] quotient_i,
    input  logic [DIVU_WIDTH-1:0] remainder_i,
    output logic [DIVU_WIDTH-1:0] dividend_o,
    output logic [DIVU_WIDTH-1:0] quotient_o,
    output logic [DIVU_WIDTH-1:0] remainder_o
);

    // The trial value can reach 2*divisor-1, so one extra bit keeps the
    // borrow of the subtraction meaningful.
    logic [DIVU_WIDTH:0] trial;
    logic [DIVU_WIDTH:0] diff;
    logic                fits;

    assign trial = {remainder_i, dividend_i[DIVU_WIDTH-1]};
    assign diff  = trial - {1'b0, divisor_i};
    assign fits  = ~diff[DIVU_WIDTH];

    assign dividend_o  = {dividend_i[DIVU_WIDTH-2:0], 1'b0};
    assign quotient_o  = {quotient_i[DIVU_WIDTH-2:0], fits};
    assign remainder_o = fits ? diff[DIVU_WIDTH-1:0] : trial[DIVU_WIDTH-1:0];

endmodule

// File: rtl/divu_seq.sv
// Sequential 32-bit divider controller: one divu_1iter step per clock.
// Defining DIVU_SIGNED_EN adds i_signed with magnitude pre/post processing.
module divu_seq
    import divu_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    divu_if.slave bus
);

    divu_state_t           state_q;
    logic [DIVU_CNT_W-1:0] cnt_q;
    logic [DIVU_WIDTH-1:0] dvd_q;
    logic [DIVU_WIDTH-1:0] dvs_q;
    logic [DIVU_WIDTH-1:0] quot_q;
    logic [DIVU_WIDTH-1:0] rem_q;
    logic                  dbz_q;
    logic                  valid_q;
    logic                  ready_q;

    logic [DIVU_WIDTH-1:0] dvd_d;
    logic [DIVU_WIDTH-1:0] quot_d;
    logic [DIVU_WIDTH-1:0] rem_d;

    logic [DIVU_WIDTH-1:0] acc_dvd;
    logic [DIVU_WIDTH-1:0] acc_dvs;

`ifdef DIVU_SIGNED_EN
    logic sgn_dvd_q;
    logic sgn_dvs_q;
    logic acc_sgn_dvd;
    logic acc_sgn_dvs;

    assign acc_sgn_dvd = bus.i_signed & bus.i_dividend[DIVU_WIDTH-1];
    assign acc_sgn_dvs = bus.i_signed & bus.i_divisor[DIVU_WIDTH-1];
    assign acc_dvd     = acc_sgn_dvd ? (~bus.i_dividend + 1'b1) : bus.i_dividend;
    assign acc_dvs     = acc_sgn_dvs ? (~bus.i_divisor + 1'b1) : bus.i_divisor;

    // Divide by zero keeps the all-ones quotient; the remainder regains the
    // dividend sign, which restores the original dividend.
    assign bus.o_quotient  = (sgn_dvd_q ^ sgn_dvs_q) && !dbz_q ? (~quot_q + 1'b1) : quot_q;
    assign bus.o_remainder = sgn_dvd_q ? (~rem_q + 1'b1) : rem_q;
`else
    assign acc_dvd         = bus.i_dividend;
    assign acc_dvs         = bus.i_divisor;
    assign bus.o_quotient  = quot_q;
    assign bus.o_remainder = rem_q;
`endif

    assign bus.o_ready       = ready_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_div_by_zero = dbz_q;

    divu_1iter u_iter (
        .dividend_i  (dvd_q),
        .divisor_i   (dvs_q),
        .quotient_i  (quot_q),
        .remainder_i (rem_q),
        .dividend_o  (dvd_d),
        .quotient_o  (quot_d),
        .remainder_o (rem_d)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= DIVU_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
`ifdef DIVU_SIGNED_EN
            sgn_dvd_q <= 1'b0;
            sgn_dvs_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                DIVU_IDLE: begin
                    if (bus.i_valid) begin
                        dvd_q     <= acc_dvd;
                        dvs_q     <= acc_dvs;
                        quot_q    <= '0;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        dbz_q     <= (bus.i_divisor == '0);
`ifdef DIVU_SIGNED_EN
                        sgn_dvd_q <= acc_sgn_dvd;
                        sgn_dvs_q <= acc_sgn_dvs;
`endif
                        ready_q   <= 1'b0;
                        state_q   <= DIVU_BUSY;
                    end
                end
                DIVU_BUSY: begin
                    dvd_q  <= dvd_d;
                    quot_q <= quot_d;
                    rem_q  <= rem_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == DIVU_LAST) begin
                        valid_q <= 1'b1;
                        state_q <= DIVU_DONE;
                    end
                end
                DIVU_DONE: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= DIVU_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= DIVU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divu_seq.sv
// Scoreboard bench for divu_seq: expected results are queued at accept and
// checked when o_valid rises. Signed cases run when DIVU_SIGNED_EN is defined.
module tb_divu_seq;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t sb[$];

    divu_if bus ();

    divu_seq u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Issue one operation; optionally queue its expected result.
    task automatic send(input logic [31:0] dvd, input logic [31:0] dvs, input logic sgn,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez,
                        input bit push);
        int n = 0;
        while (bus.o_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL send_ready_timeout: o_ready=%b required 1", bus.o_ready);
        end
        bus.i_valid    = 1'b1;
        bus.i_dividend = dvd;
        bus.i_divisor  = dvs;
`ifdef DIVU_SIGNED_EN
        bus.i_signed   = sgn;
`endif
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        if (push) sb.push_back('{eq, er, ez});
        $display("send dvd=%h dvs=%h sgn=%b", dvd, dvs, sgn);
    endtask

    // Cycles from accept until o_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.o_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 100) begin
            total++; bad++;
            $display("FAIL valid_timeout: o_valid=%b required 1", bus.o_valid);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_dividend = '0;
        bus.i_divisor  = '0;
`ifdef DIVU_SIGNED_EN
        bus.i_signed   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
        total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.o_ready); end
        total++; if (bus.o_quotient !== 32'h0) begin bad++; $display("FAIL reset_q: got %h want 0", bus.o_quotient); end
        total++; if (bus.o_remainder !== 32'h0) begin bad++; $display("FAIL reset_r: got %h want 0", bus.o_remainder); end
        total++; if (bus.o_div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", bus.o_div_by_zero); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset done");
    endtask

    task automatic test_unsigned();
        logic [31:0] dvd_t [3] = '{32'd100, 32'hFFFF_FFFF, 32'h0000_1234};
        logic [31:0] dvs_t [3] = '{32'd7,   32'd1,         32'd0};
        logic [31:0] q_t   [3] = '{32'd14,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] r_t   [3] = '{32'd2,   32'd0,         32'h0000_1234};
        logic        z_t   [3] = '{1'b0,    1'b0,          1'b1};
        int lat;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            send(dvd_t[i], dvs_t[i], 1'b0, q_t[i], r_t[i], z_t[i], 1'b1);
            wait_valid(lat);
            total++; if (lat !== 32) begin bad++; $display("FAIL unsigned_latency[%0d]: got %0d want 32", i, lat); end
            if (sb.size() == 0) begin
                total++; bad++; $display("FAIL unsigned_sb_empty[%0d]: got 0 entries want 1", i);
            end else begin
                e = sb.pop_front();
                total++; if (bus.o_quotient !== e.q) begin bad++; $display("FAIL unsigned_q[%0d]: got %h want %h", i, bus.o_quotient, e.q); end
                total++; if (bus.o_remainder !== e.r) begin bad++; $display("FAIL unsigned_r[%0d]: got %h want %h", i, bus.o_remainder, e.r); end
                total++; if (bus.o_div_by_zero !== e.z) begin bad++; $display("FAIL unsigned_dbz[%0d]: got %b want %b", i, bus.o_div_by_zero, e.z); end
            end
            bus.i_ready = 1'b1;
            @(posedge clk); #1;
            bus.i_ready = 1'b0;
            total++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
                bad++; $display("FAIL unsigned_release[%0d]: valid=%b ready=%b want 0/1", i, bus.o_valid, bus.o_ready);
            end
            $display("unsigned op %0d: q=%h r=%h dbz=%b lat=%0d", i, bus.o_quotient, bus.o_remainder, bus.o_div_by_zero, lat);
        end
    endtask

    task automatic test_backpressure();
        int lat = 0;
        exp_t e;
        send(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 1'b1);
        repeat (4) begin @(posedge clk); #1; lat++; end
        // Intruding request while busy must be ignored.
        bus.i_valid    = 1'b1;
        bus.i_dividend = 32'd1;
        bus.i_divisor  = 32'd1;
        total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL bp_busy_ready: got %b want 0", bus.o_ready); end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        wait_valid(lat);
        if (sb.size() == 0) begin
            total++; bad++; $display("FAIL bp_sb_empty: got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            for (int c = 0; c < 5; c++) begin
                total++;
                if (bus.o_valid !== 1'b1 || bus.o_quotient !== e.q || bus.o_remainder !== e.r || bus.o_div_by_zero !== e.z) begin
                    bad++;
                    $display("FAIL bp_hold[%0d]: valid=%b q=%h r=%h want 1 q=%h r=%h", c, bus.o_valid, bus.o_quotient, bus.o_remainder, e.q, e.r);
                end
                @(posedge clk); #1;
            end
        end
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        total++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", bus.o_valid, bus.o_ready);
        end
        $display("backpressure op: q=%h r=%h", bus.o_quotient, bus.o_remainder);
    endtask

    task automatic test_reset_mid();
        int lat;
        exp_t e;
        send(32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", bus.o_valid); end
        total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", bus.o_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b1);
        wait_valid(lat);
        if (sb.size() == 0) begin
            total++; bad++; $display("FAIL midrst_sb_empty: got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            total++; if (bus.o_quotient !== e.q || bus.o_remainder !== e.r) begin
                bad++; $display("FAIL midrst_next: q=%h r=%h want q=%h r=%h", bus.o_quotient, bus.o_remainder, e.q, e.r);
            end
        end
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        $display("mid-op reset then 9/3: q=%h r=%h", bus.o_quotient, bus.o_remainder);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        int lat;
        exp_t e;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = $urandom();
            case (i)
                0: b = 32'd0;
                1: b = 32'd1;
                2: b = $urandom_range(2, 255);
                default: b = $urandom();
            endcase
            if (b == 0) send(a, b, 1'b0, 32'hFFFF_FFFF, a, 1'b1, 1'b1);
            else        send(a, b, 1'b0, a / b, a % b, 1'b0, 1'b1);
            wait_valid(lat);
            if (sb.size() == 0) begin
                total++; bad++; $display("FAIL b2b_sb_empty[%0d]: got 0 entries want 1", i);
            end else begin
                e = sb.pop_front();
                total++;
                if (bus.o_quotient !== e.q || bus.o_remainder !== e.r || bus.o_div_by_zero !== e.z) begin
                    bad++;
                    $display("FAIL b2b[%0d]: q=%h r=%h z=%b want q=%h r=%h z=%b", i, bus.o_quotient, bus.o_remainder, bus.o_div_by_zero, e.q, e.r, e.z);
                end
            end
            $display("b2b op %0d: %h/%h q=%h r=%h", i, a, b, bus.o_quotient, bus.o_remainder);
        end
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
    endtask

`ifdef DIVU_SIGNED_EN
    task automatic test_signed();
        logic [31:0] dvd_t [4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFB, 32'h8000_0000};
        logic [31:0] dvs_t [4] = '{32'd2,         32'hFFFF_FFFF, 32'd0,         32'd2};
        logic        sg_t  [4] = '{1'b1,          1'b1,          1'b1,          1'b0};
        logic [31:0] q_t   [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h4000_0000};
        logic [31:0] r_t   [4] = '{32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFB, 32'd0};
        logic        z_t   [4] = '{1'b0,          1'b0,          1'b1,          1'b0};
        int lat;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            send(dvd_t[i], dvs_t[i], sg_t[i], q_t[i], r_t[i], z_t[i], 1'b1);
            wait_valid(lat);
            if (sb.size() == 0) begin
                total++; bad++; $display("FAIL signed_sb_empty[%0d]: got 0 entries want 1", i);
            end else begin
                e = sb.pop_front();
                total++; if (bus.o_quotient !== e.q) begin bad++; $display("FAIL signed_q[%0d]: got %h want %h", i, bus.o_quotient, e.q); end
                total++; if (bus.o_remainder !== e.r) begin bad++; $display("FAIL signed_r[%0d]: got %h want %h", i, bus.o_remainder, e.r); end
                total++; if (bus.o_div_by_zero !== e.z) begin bad++; $display("FAIL signed_dbz[%0d]: got %b want %b", i, bus.o_div_by_zero, e.z); end
            end
            bus.i_ready = 1'b1;
            @(posedge clk); #1;
            bus.i_ready = 1'b0;
            $display("signed op %0d: q=%h r=%h", i, bus.o_quotient, bus.o_remainder);
        end
        bus.i_signed = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef DIVU_SIGNED_EN
        test_signed();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
